// File: rtl/multdiv_ctrl.sv
// Sequencer for the shared iterative mult/div unit: accepts an op from DX, starts the unit, holds the result for writeback.
// Optional op timeout enabled by defining MULTDIV_TIMEOUT_EN.
module multdiv_ctrl #(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W          = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dx_ir,
  input  logic        dx_new,
  input  logic [31:0] dx_operand_a,
  input  logic [31:0] dx_operand_b,
  input  logic        flush,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic [31:0] md_operand_a,
  output logic [31:0] md_operand_b,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_result_rdy,
  input  logic        wb_ack,
  output logic        multdiv_is_running,
  output logic        multdiv_result_ready,
  output logic [31:0] result,
  output logic [4:0]  result_rd,
  output logic        result_exception
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_BUSY,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic [4:0]  EXC_RD       = 5'd30;
  localparam logic [31:0] EXC_MULT_VAL = 32'd4;
  localparam logic [31:0] EXC_DIV_VAL  = 32'd5;

  state_e      state_q;
  logic        op_div_q;
  logic [4:0]  rd_q;
  logic [31:0] opa_q, opb_q;
  logic        ctrl_mult_q, ctrl_div_q;
  logic        running_q, ready_q;
  logic [31:0] result_q, result_d;
  logic [4:0]  result_rd_q, result_rd_d;
  logic        result_exc_q, result_exc_d;

  logic is_mult, is_div, accept, timeout_hit;
  logic unused_ir_bits;

  assign is_mult = (dx_ir[31:27] == 5'b00000) && (dx_ir[6:2] == 5'b00110);
  assign is_div  = (dx_ir[31:27] == 5'b00000) && (dx_ir[6:2] == 5'b00111);
  assign accept  = (state_q == S_IDLE) && dx_new && (is_mult || is_div) && !flush;
  assign unused_ir_bits = ^{dx_ir[21:7], dx_ir[1:0]};

`ifdef MULTDIV_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign cnt_d       = cnt_q + 1'b1;
  assign timeout_hit = (cnt_d == CNT_W'(TIMEOUT_CYCLES));

  // Counts cycles spent in ISSUE/BUSY/DRAIN; running_q is high exactly in those states.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if (running_q) begin
      cnt_q <= cnt_d;
    end
  end
`else
  localparam int unused_timeout_cfg = TIMEOUT_CYCLES + CNT_W;
  assign timeout_hit = 1'b0;
`endif

  // A timeout (no ready pulse) is reported the same way as a unit exception.
  always_comb begin
    result_d     = md_result;
    result_rd_d  = rd_q;
    result_exc_d = 1'b0;
    if (!md_result_rdy || md_exception) begin
      result_d     = op_div_q ? EXC_DIV_VAL : EXC_MULT_VAL;
      result_rd_d  = EXC_RD;
      result_exc_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: every register, including the data holding registers, is reset so outputs are 0 immediately.
      state_q      <= S_IDLE;
      op_div_q     <= 1'b0;
      rd_q         <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      ctrl_mult_q  <= 1'b0;
      ctrl_div_q   <= 1'b0;
      running_q    <= 1'b0;
      ready_q      <= 1'b0;
      result_q     <= '0;
      result_rd_q  <= '0;
      result_exc_q <= 1'b0;
    end else begin
      // NOTE: start pulses default low so they can only be high for the single ISSUE cycle.
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q     <= S_ISSUE;
            op_div_q    <= is_div;
            rd_q        <= dx_ir[26:22];
            opa_q       <= dx_operand_a;
            opb_q       <= dx_operand_b;
            ctrl_mult_q <= is_mult;
            ctrl_div_q  <= is_div;
            running_q   <= 1'b1;
          end
        end
        S_ISSUE: begin
          state_q <= flush ? S_DRAIN : S_BUSY;
        end
        S_BUSY: begin
          if (flush) begin
            if (md_result_rdy || timeout_hit) begin
              state_q   <= S_IDLE;
              running_q <= 1'b0;
            end else begin
              state_q <= S_DRAIN;
            end
          end else if (md_result_rdy || timeout_hit) begin
            state_q      <= S_DONE;
            running_q    <= 1'b0;
            ready_q      <= 1'b1;
            result_q     <= result_d;
            result_rd_q  <= result_rd_d;
            result_exc_q <= result_exc_d;
          end
        end
        S_DRAIN: begin
          if (md_result_rdy || timeout_hit) begin
            state_q   <= S_IDLE;
            running_q <= 1'b0;
          end
        end
        S_DONE: begin
          if (wb_ack) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          running_q <= 1'b0;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  assign md_ctrl_mult         = ctrl_mult_q;
  assign md_ctrl_div          = ctrl_div_q;
  assign md_operand_a         = opa_q;
  assign md_operand_b         = opb_q;
  assign multdiv_is_running   = running_q;
  assign multdiv_result_ready = ready_q;
  assign result               = result_q;
  assign result_rd            = result_rd_q;
  assign result_exception     = result_exc_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: table of complete ops plus directed flush/stall/reset/timeout sequences.
module tb_multdiv_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] dx_ir, dx_operand_a, dx_operand_b;
  logic        dx_new, flush;
  logic        md_ctrl_mult, md_ctrl_div;
  logic [31:0] md_operand_a, md_operand_b;
  logic [31:0] md_result;
  logic        md_exception, md_result_rdy, wb_ack;
  logic        multdiv_is_running, multdiv_result_ready;
  logic [31:0] result;
  logic [4:0]  result_rd;
  logic        result_exception;

  int n_checks = 0;
  int n_errors = 0;

  multdiv_ctrl #(.TIMEOUT_CYCLES(40), .CNT_W(6)) dut (
    .clock(clock), .reset(reset),
    .dx_ir(dx_ir), .dx_new(dx_new),
    .dx_operand_a(dx_operand_a), .dx_operand_b(dx_operand_b),
    .flush(flush),
    .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
    .md_operand_a(md_operand_a), .md_operand_b(md_operand_b),
    .md_result(md_result), .md_exception(md_exception), .md_result_rdy(md_result_rdy),
    .wb_ack(wb_ack),
    .multdiv_is_running(multdiv_is_running), .multdiv_result_ready(multdiv_result_ready),
    .result(result), .result_rd(result_rd), .result_exception(result_exception)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        div;
    logic [4:0]  rd;
    logic [31:0] a, b;
    int          lat;
    logic [31:0] unit_res;
    logic        unit_exc;
    logic [31:0] exp_res;
    logic [4:0]  exp_rd;
    logic        exp_exc;
    int          exp_run;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_ir(input logic div, input logic [4:0] rd);
    logic [31:0] ir;
    ir        = '0;
    ir[26:22] = rd;
    ir[21:17] = 5'd1;
    ir[16:12] = 5'd2;
    ir[6:2]   = div ? 5'b00111 : 5'b00110;
    return ir;
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Presents one op for one cycle; on return the DUT is in ISSUE.
  task automatic issue(input logic div, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
    dx_ir = mk_ir(div, rd);
    dx_operand_a = a;
    dx_operand_b = b;
    dx_new = 1'b1;
    tick;
    dx_new = 1'b0;
    dx_ir  = '0;
  endtask

  // Unit model: ready pulse sampled lat cycles after the start pulse was seen.
  task automatic wait_rdy(input int lat, input logic [31:0] res, input logic exc,
                          output int run_cnt, output int pulses);
    run_cnt = multdiv_is_running ? 1 : 0;
    pulses  = 0;
    for (int k = 1; k <= lat + 1; k++) begin
      if (k == lat + 1) begin
        md_result_rdy = 1'b1;
        md_result     = res;
        md_exception  = exc;
      end
      tick;
      md_result_rdy = 1'b0;
      md_exception  = 1'b0;
      md_result     = 32'hbad0_bad0;
      run_cnt += multdiv_is_running ? 1 : 0;
      pulses  += (md_ctrl_mult | md_ctrl_div) ? 1 : 0;
    end
  endtask

  task automatic ack;
    wb_ack = 1'b1;
    tick;
    wb_ack = 1'b0;
  endtask

  initial begin
    int run_cnt, pulses, bad, rdy_seen;

    vecs[0] = '{1'b0, 5'd5,  32'd7,          32'd6, 32, 32'd42,         1'b0, 32'd42,         5'd5,  1'b0, 33};
    vecs[1] = '{1'b1, 5'd3,  32'd9,          32'd0, 4,  32'hdead,       1'b1, 32'd5,          5'd30, 1'b1, 5};
    vecs[2] = '{1'b0, 5'd12, 32'hffff_fffd,  32'd5, 1,  32'hffff_fff1,  1'b0, 32'hffff_fff1,  5'd12, 1'b0, 2};
    vecs[3] = '{1'b0, 5'd7,  32'h8000_0000,  32'd2, 2,  32'h1234,       1'b1, 32'd4,          5'd30, 1'b1, 3};
    vecs[4] = '{1'b1, 5'd0,  32'd100,        32'd7, 10, 32'd14,         1'b0, 32'd14,         5'd0,  1'b0, 11};
    vecs[5] = '{1'b1, 5'd31, 32'd20,         32'd4, 3,  32'd5,          1'b0, 32'd5,          5'd31, 1'b0, 4};

    reset = 1'b1;
    dx_ir = '0; dx_new = 1'b0; dx_operand_a = '0; dx_operand_b = '0; flush = 1'b0;
    md_result = '0; md_exception = 1'b0; md_result_rdy = 1'b0; wb_ack = 1'b0;
    tick;
    tick;
    check("reset_running", multdiv_is_running, 0);
    check("reset_ready", multdiv_result_ready, 0);
    check("reset_ctrl", {md_ctrl_mult, md_ctrl_div}, 0);
    check("reset_result", {result_exception, result_rd, result}, 0);
    reset = 1'b0;
    tick;

    for (int i = 0; i < 6; i++) begin
      issue(vecs[i].div, vecs[i].rd, vecs[i].a, vecs[i].b);
      check($sformatf("v%0d_ctrl_mult", i), md_ctrl_mult, !vecs[i].div);
      check($sformatf("v%0d_ctrl_div", i), md_ctrl_div, vecs[i].div);
      check($sformatf("v%0d_opa", i), md_operand_a, vecs[i].a);
      check($sformatf("v%0d_opb", i), md_operand_b, vecs[i].b);
      wait_rdy(vecs[i].lat, vecs[i].unit_res, vecs[i].unit_exc, run_cnt, pulses);
      check($sformatf("v%0d_run_cycles", i), run_cnt, vecs[i].exp_run);
      check($sformatf("v%0d_extra_pulses", i), pulses, 0);
      check($sformatf("v%0d_ready", i), multdiv_result_ready, 1);
      check($sformatf("v%0d_result", i), result, vecs[i].exp_res);
      check($sformatf("v%0d_rd", i), result_rd, vecs[i].exp_rd);
      check($sformatf("v%0d_exc", i), result_exception, vecs[i].exp_exc);
      ack;
      check($sformatf("v%0d_ready_clear", i), multdiv_result_ready, 0);
    end

    // Non-mult/div opcode and flushed dx_new must not start anything.
    dx_ir = mk_ir(1'b0, 5'd3);
    dx_ir[31:27] = 5'b00001;
    dx_new = 1'b1;
    tick;
    dx_new = 1'b0;
    check("nonmd_not_accepted", {multdiv_is_running, md_ctrl_mult, md_ctrl_div}, 0);
    flush = 1'b1;
    issue(1'b1, 5'd3, 32'd1, 32'd1);
    flush = 1'b0;
    check("flush_blocks_accept", {multdiv_is_running, md_ctrl_mult, md_ctrl_div}, 0);

    // Flush in the first BUSY cycle: drain until the unit answers, no result.
    issue(1'b0, 5'd9, 32'd11, 32'd13);
    tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      bad += (!multdiv_is_running || multdiv_result_ready) ? 1 : 0;
      tick;
    end
    check("drain_running_no_ready", bad, 0);
    md_result_rdy = 1'b1;
    md_result = 32'd123;
    tick;
    md_result_rdy = 1'b0;
    check("drain_exit", {multdiv_is_running, multdiv_result_ready}, 0);
    issue(1'b1, 5'd4, 32'd50, 32'd5);
    check("after_drain_div_pulse", {md_ctrl_mult, md_ctrl_div}, 2'b01);
    wait_rdy(3, 32'd10, 1'b0, run_cnt, pulses);
    check("after_drain_result", {result_rd, result}, {5'd4, 32'd10});
    ack;

    // Flush during ISSUE goes to DRAIN.
    issue(1'b0, 5'd2, 32'd1, 32'd2);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    check("issue_flush_running", multdiv_is_running, 1);
    md_result_rdy = 1'b1;
    tick;
    md_result_rdy = 1'b0;
    check("issue_flush_exit", {multdiv_is_running, multdiv_result_ready}, 0);

    // Flush together with ready in BUSY discards the result.
    issue(1'b0, 5'd2, 32'd1, 32'd2);
    tick;
    flush = 1'b1;
    md_result_rdy = 1'b1;
    tick;
    flush = 1'b0;
    md_result_rdy = 1'b0;
    tick;
    check("flush_rdy_discard", {multdiv_is_running, multdiv_result_ready}, 0);

    // DONE held for 10 cycles with dx_new pulses and a flush.
    issue(1'b0, 5'd6, 32'd3, 32'd4);
    wait_rdy(5, 32'd12, 1'b0, run_cnt, pulses);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      dx_ir = mk_ir(1'b1, 5'd1);
      dx_operand_a = 32'hffff_0000 + k;
      dx_new = (k % 2 == 0);
      flush = (k == 3);
      tick;
      bad += (multdiv_result_ready !== 1'b1 || result !== 32'd12 || result_rd !== 5'd6 ||
              result_exception !== 1'b0 || multdiv_is_running !== 1'b0 ||
              md_ctrl_mult || md_ctrl_div || md_operand_a !== 32'd3) ? 1 : 0;
    end
    dx_new = 1'b0;
    flush = 1'b0;
    dx_ir = '0;
    check("done_stall_stable", bad, 0);
    ack;
    tick;
    check("done_stall_release", {multdiv_result_ready, multdiv_is_running, md_ctrl_mult, md_ctrl_div}, 0);

`ifdef MULTDIV_TIMEOUT_EN
    issue(1'b0, 5'd8, 32'd5, 32'd5);
    run_cnt = 1;
    rdy_seen = 0;
    for (int k = 0; k < 60 && rdy_seen == 0; k++) begin
      tick;
      run_cnt += multdiv_is_running ? 1 : 0;
      rdy_seen = multdiv_result_ready ? 1 : 0;
    end
    check("timeout_reached", rdy_seen, 1);
    check("timeout_cycles", run_cnt, 40);
    check("timeout_result", {result_exception, result_rd, result}, {1'b1, 5'd30, 32'd4});
    ack;
    issue(1'b0, 5'd8, 32'd5, 32'd5);
    wait_rdy(39, 32'd77, 1'b0, run_cnt, pulses);
    check("limit_rdy_cycles", run_cnt, 40);
    check("limit_rdy_result", {result_exception, result_rd, result}, {1'b0, 5'd8, 32'd77});
    ack;
`else
    issue(1'b0, 5'd8, 32'd5, 32'd5);
    for (int k = 0; k < 45; k++) tick;
    check("no_timeout_running", {multdiv_is_running, multdiv_result_ready}, 2'b10);
    md_result_rdy = 1'b1;
    md_result = 32'd77;
    tick;
    md_result_rdy = 1'b0;
    check("no_timeout_result", {multdiv_result_ready, result_rd, result}, {1'b1, 5'd8, 32'd77});
    ack;
`endif

    // Asynchronous reset in the middle of BUSY.
    issue(1'b1, 5'd10, 32'd99, 32'd3);
    tick;
    tick;
    reset = 1'b1;
    #1;
    check("mid_reset_running", multdiv_is_running, 0);
    check("mid_reset_operands", {md_operand_a, md_operand_b}, 0);
    check("mid_reset_result", {multdiv_result_ready, result_exception, result_rd, result}, 0);
    #2;
    reset = 1'b0;
    pulses = 0;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      tick;
      pulses += (md_ctrl_mult | md_ctrl_div) ? 1 : 0;
      bad += multdiv_is_running ? 1 : 0;
    end
    check("post_reset_no_pulse", pulses, 0);
    check("post_reset_idle", bad, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
- Sequencer for the shared iterative mult/div unit in the 5-stage pipeline.
- Accepts a mult or div instruction newly presented in DX and latches its operands and destination register.
- Pulses the unit's start control, tracks it to completion and holds the result until writeback acknowledges it.
- Drives multdiv_is_running and multdiv_result_ready to the stall logic.

Parameters:
- TIMEOUT_CYCLES, 40, maximum cycles from ISSUE to md_result_rdy before the op is abandoned; used only with the optional feature.
- CNT_W, 6, width of the cycle counter; must hold TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- dx_ir  in  32  instruction in DX.
- dx_new  in  1  one-cycle qualifier: dx_ir is newly presented this cycle.
- dx_operand_a  in  32  bypassed rs value.
- dx_operand_b  in  32  bypassed rt value.
- flush  in  1  squash the in-flight op (branch or jump taken).
- md_ctrl_mult  out  1  start-mult pulse to the unit.
- md_ctrl_div  out  1  start-div pulse to the unit.
- md_operand_a  out  32  latched operand A, held stable.
- md_operand_b  out  32  latched operand B, held stable.
- md_result  in  32  unit result.
- md_exception  in  1  unit exception, valid with md_result_rdy.
- md_result_rdy  in  1  unit done, one-cycle pulse.
- wb_ack  in  1  writeback has consumed the result.
- multdiv_is_running  out  1  op in flight.
- multdiv_result_ready  out  1  result held for writeback.
- result  out  32  writeback data.
- result_rd  out  5  writeback register.
- result_exception  out  1  result is an exception status.

Behaviour:
- Decode
  - mult: dx_ir[31:27]=00000 and dx_ir[6:2]=00110.
  - div: dx_ir[31:27]=00000 and dx_ir[6:2]=00111.
  - rd = dx_ir[26:22].
- States: IDLE, ISSUE, BUSY, DRAIN, DONE. All outputs are registered.
- Reset: asynchronous. State goes to IDLE. Every output and internal register clears to 0.
- IDLE
  - Accept when dx_new, decode is mult or div, and flush=0.
  - On accept: latch operands, rd and op type; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle)
  - Exactly one of md_ctrl_mult / md_ctrl_div is high for this cycle only.
  - Next state is BUSY, or DRAIN if flush=1.
- BUSY
  - md_result_rdy=1 → DONE, capturing the result. If flush is also 1, flush wins → IDLE and the result is discarded.
  - flush=1 alone → DRAIN.
  - Otherwise stay in BUSY.
- DRAIN
  - Wait for md_result_rdy, discard the result, then go to IDLE.
  - This state exists so a squashed op never collides with a new start.
- DONE
  - multdiv_result_ready=1; result, result_rd and result_exception are held stable.
  - wb_ack=1 → IDLE, and ready clears the next cycle.
  - dx_new is ignored in DONE (stall logic prevents it).
  - flush does not discard a DONE result.
- multdiv_is_running = 1 in ISSUE, BUSY and DRAIN; 0 in IDLE and DONE.
- md_ctrl_* is 0 in every state except ISSUE.
- Exception capture
  - md_exception=1 with md_result_rdy: result_rd=30, result=4 for mult or 5 for div, result_exception=1.
  - Otherwise: result=md_result, result_rd=latched rd, result_exception=0.
- rd=0 is still sequenced normally; writeback drops it.
- md_operands change only on accept.

Optional Feature:
- Macro: MULTDIV_TIMEOUT_EN.
- Defined
  - A CNT_W-bit counter clears on entering ISSUE and increments each cycle in ISSUE, BUSY and DRAIN.
  - BUSY with count reaching TIMEOUT_CYCLES and no md_result_rdy → DONE as an exception (result_rd=30, result=4 or 5, result_exception=1).
  - DRAIN with the same condition → IDLE.
  - md_result_rdy on the same cycle as the limit takes priority over the timeout.
- Undefined: no counter logic; BUSY and DRAIN wait indefinitely.

Test Plan:
- Reset asserted mid-BUSY → all outputs 0 immediately; state IDLE; no md_ctrl pulse after reset deasserts.
- mult, rd=5, A=7, B=6; unit rdy after 32 cycles with result 42 → one-cycle md_ctrl_mult; running=1 for 33 cycles; ready=1 with result=42, rd=5; wb_ack clears ready next cycle.
- div, A=9, B=0; unit returns exception → result_rd=30, result=5, result_exception=1.
- flush one cycle after ISSUE → DRAIN; running stays 1 until rdy; ready never asserts; new div accepted on the next dx_new.
- wb_ack held 0 for 10 cycles in DONE with dx_new pulses → outputs stable; no new md_ctrl pulse.
- With MULTDIV_TIMEOUT_EN, TIMEOUT_CYCLES=40, rdy never arrives → DONE with result=4 (mult) at cycle 40; rdy arriving exactly at cycle 40 → normal result.
